// File: rtl/alu_pkg.sv
// Shared types and field layout for the ALU operation word and its sequencer.
package alu_pkg;

    localparam int OPW_W    = 15;
    localparam int CTRL_MSB = 14;
    localparam int CTRL_LSB = 12;
    localparam int A_MSB    = 11;
    localparam int A_LSB    = 6;
    localparam int B_MSB    = 5;
    localparam int B_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        DWELL
    } seq_state_t;

    // Bits needed to hold any value in 0..max_value (never less than one).
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/alu_sequencer_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/alu_sequencer_split.sv
// Splits a queued operation word into its control, A and B fields.
module split
    import alu_pkg::*;
(
    input  logic [OPW_W-1:0]           word_i,
    output logic [CTRL_MSB-CTRL_LSB:0] control_o,
    output logic [A_MSB-A_LSB:0]       a_o,
    output logic [B_MSB-B_LSB:0]       b_o
);

    assign control_o = word_i[CTRL_MSB:CTRL_LSB];
    assign a_o       = word_i[A_MSB:A_LSB];
    assign b_o       = word_i[B_MSB:B_LSB];

endmodule

// File: rtl/alu_sequencer.sv
// Drains operation words from the ALU FIFO, presents each to the operations unit
// and holds the result for a dwell period (auto) or until a step pulse (step).
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int RD_LATENCY   = 1,
    parameter int OP_LATENCY   = 1,
    parameter int CNT_W        = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       run_mode,
    input  logic                       step,
    input  logic                       empty,
    input  logic [OPW_W-1:0]           rd_data,
    input  logic                       ovf_in,
    output logic                       ren,
    output logic                       op_valid,
    output logic [CTRL_MSB-CTRL_LSB:0] op_control,
    output logic [A_MSB-A_LSB:0]       op_a,
    output logic [B_MSB-B_LSB:0]       op_b,
    output logic                       busy,
    output logic                       holding,
    output logic [CNT_W-1:0]           ops_done,
    output logic [CNT_W-1:0]           ovf_count
);

    localparam int LAT_MAX = (RD_LATENCY > OP_LATENCY) ? RD_LATENCY : OP_LATENCY;
    localparam int LAT_W   = cnt_width(LAT_MAX);
    localparam int DW_W    = cnt_width(DWELL_CYCLES);

    localparam logic [LAT_W-1:0] RD_LAST = LAT_W'(RD_LATENCY - 1);
    localparam logic [LAT_W-1:0] OP_LAST = LAT_W'(OP_LATENCY - 1);
    localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL_CYCLES - 1);

    seq_state_t                 state_q;
    logic [LAT_W-1:0]           lat_q;
    logic [DW_W-1:0]            dwell_q;
    logic                       armed_q;
    logic                       op_valid_q;
    logic                       busy_q;
    logic                       holding_q;
    logic [CTRL_MSB-CTRL_LSB:0] op_control_q;
    logic [A_MSB-A_LSB:0]       op_a_q;
    logic [B_MSB-B_LSB:0]       op_b_q;

    logic [CTRL_MSB-CTRL_LSB:0] f_control;
    logic [A_MSB-A_LSB:0]       f_a;
    logic [B_MSB-B_LSB:0]       f_b;
    logic                       issue;
    logic                       exec_done;
    logic                       ovf_inc;

    split u_split (
        .word_i    (rd_data),
        .control_o (f_control),
        .a_o       (f_a),
        .b_o       (f_b)
    );

    // ren is decoded in the IDLE cycle itself so it can never coincide with empty
    // and so the issue interval is exactly 1 + RD_LATENCY + OP_LATENCY + DWELL_CYCLES.
    assign issue     = (state_q == IDLE) && armed_q && !empty;
    assign exec_done = (state_q == EXEC) && (lat_q == OP_LAST);
    assign ovf_inc   = exec_done && ovf_in;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            dwell_q      <= '0;
            armed_q      <= 1'b0;
            op_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            holding_q    <= 1'b0;
            op_control_q <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
        end else begin
            armed_q    <= 1'b1;
            op_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= FETCH;
                        lat_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (lat_q == RD_LAST) begin
                        op_control_q <= f_control;
                        op_a_q       <= f_a;
                        op_b_q       <= f_b;
                        op_valid_q   <= 1'b1;
                        lat_q        <= '0;
                        state_q      <= EXEC;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        lat_q     <= '0;
                        dwell_q   <= '0;
                        holding_q <= 1'b1;
                        state_q   <= DWELL;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                DWELL: begin
                    // In step mode the dwell count is frozen, so auto resumes where it left off.
                    if (run_mode ? (dwell_q == DW_LAST) : step) begin
                        busy_q    <= 1'b0;
                        holding_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (run_mode) begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_ops_done (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clear_i (1'b0),
        .inc_i   (exec_done),
        .count_o (ops_done)
    );

    sat_counter #(.W(CNT_W)) u_ovf_count (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clear_i (1'b0),
        .inc_i   (ovf_inc),
        .count_o (ovf_count)
    );

    assign ren        = issue;
    assign op_valid   = op_valid_q;
    assign op_control = op_control_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign busy       = busy_q;
    assign holding    = holding_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: FIFO and operations-unit models plus per-scenario checks.
`timescale 1ns/1ps
module tb_alu_sequencer;

    localparam int DW = 4;
    localparam int CW = 2;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic          run_mode = 1'b1;
    logic          step     = 1'b0;
    logic          empty;
    logic [14:0]   rd_data  = '0;
    logic          ovf_in   = 1'b0;
    logic          ren;
    logic          op_valid;
    logic [2:0]    op_control;
    logic [5:0]    op_a;
    logic [5:0]    op_b;
    logic          busy;
    logic          holding;
    logic [CW-1:0] ops_done;
    logic [CW-1:0] ovf_count;

    alu_sequencer #(
        .DWELL_CYCLES (DW),
        .RD_LATENCY   (1),
        .OP_LATENCY   (1),
        .CNT_W        (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run_mode   (run_mode),
        .step       (step),
        .empty      (empty),
        .rd_data    (rd_data),
        .ovf_in     (ovf_in),
        .ren        (ren),
        .op_valid   (op_valid),
        .op_control (op_control),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .holding    (holding),
        .ops_done   (ops_done),
        .ovf_count  (ovf_count)
    );

    always #5 clock = ~clock;

    // FIFO model: written by the stimulus, popped on ren with one cycle read latency.
    logic [14:0] fifo_mem [0:63];
    int          pushed_n = 0;
    int          popped_n = 0;
    // Overflow plan: one bit per issued operation, presented while op_valid is high.
    logic        ovf_mem [0:63];
    int          ovf_wr = 0;
    int          ovf_rd = 0;

    assign empty = (pushed_n == popped_n);

    int          cyc = 0;
    int          ren_cyc[$];
    int          opv_cyc[$];
    logic [14:0] op_seen[$];
    int          hold_cnt = 0;
    int          ren_empty_err = 0;

    int checks = 0;
    int passes = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (ren && (pushed_n != popped_n)) begin
            rd_data  <= fifo_mem[popped_n % 64];
            popped_n <= popped_n + 1;
        end
    end

    always @(negedge clock) begin
        if (ren) begin
            ren_cyc.push_back(cyc);
            if (empty) ren_empty_err <= ren_empty_err + 1;
        end
        if (op_valid) begin
            opv_cyc.push_back(cyc);
            op_seen.push_back({op_control, op_a, op_b});
            if (ovf_rd != ovf_wr) begin
                ovf_in <= ovf_mem[ovf_rd % 64];
                ovf_rd <= ovf_rd + 1;
            end else begin
                ovf_in <= 1'b0;
            end
        end else begin
            ovf_in <= 1'b0;
        end
        if (holding) hold_cnt <= hold_cnt + 1;
    end

    task automatic push_word(input logic [14:0] w, input logic ovf);
        fifo_mem[pushed_n % 64] = w;
        ovf_mem[ovf_wr % 64]    = ovf;
        pushed_n = pushed_n + 1;
        ovf_wr   = ovf_wr + 1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        step  = 1'b0;
        repeat (2) @(negedge clock);
        pushed_n = popped_n;
        ovf_wr   = ovf_rd;
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        int rb;
        #2 reset = 1'b0;
        #1;
        checks++; if (ren !== 1'b0) $display("FAIL rst_ren got %b want 0", ren); else passes++;
        checks++; if (op_valid !== 1'b0) $display("FAIL rst_op_valid got %b want 0", op_valid); else passes++;
        checks++; if (op_control !== 3'd0) $display("FAIL rst_op_control got %0d want 0", op_control); else passes++;
        checks++; if (op_a !== 6'd0) $display("FAIL rst_op_a got %0d want 0", op_a); else passes++;
        checks++; if (op_b !== 6'd0) $display("FAIL rst_op_b got %0d want 0", op_b); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passes++;
        checks++; if (holding !== 1'b0) $display("FAIL rst_holding got %b want 0", holding); else passes++;
        checks++; if (ops_done !== 2'd0) $display("FAIL rst_ops_done got %0d want 0", ops_done); else passes++;
        checks++; if (ovf_count !== 2'd0) $display("FAIL rst_ovf_count got %0d want 0", ovf_count); else passes++;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        run_mode = 1'b1;
        rb = ren_cyc.size();
        repeat (20) @(negedge clock);
        #1;
        checks++; if (ren_cyc.size() - rb != 0) $display("FAIL idle_ren got %0d pulses want 0", ren_cyc.size() - rb); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else passes++;
        checks++; if (ops_done !== 2'd0) $display("FAIL idle_ops_done got %0d want 0", ops_done); else passes++;
        checks++; if (ovf_count !== 2'd0) $display("FAIL idle_ovf_count got %0d want 0", ovf_count); else passes++;
    endtask

    task automatic test_single();
        int rb, ob, hb, gap;
        do_reset();
        run_mode = 1'b1;
        rb = ren_cyc.size(); ob = opv_cyc.size(); hb = hold_cnt;
        push_word(15'b001_000011_000010, 1'b0);
        repeat (20) @(negedge clock);
        #1;
        gap = (ren_cyc.size() > rb && opv_cyc.size() > ob) ? opv_cyc[ob] - ren_cyc[rb] : -1;
        checks++; if (ren_cyc.size() - rb != 1) $display("FAIL single_ren_count got %0d want 1", ren_cyc.size() - rb); else passes++;
        checks++; if (opv_cyc.size() - ob != 1) $display("FAIL single_opv_count got %0d want 1", opv_cyc.size() - ob); else passes++;
        checks++; if (gap != 2) $display("FAIL single_ren_to_opv got %0d want 2", gap); else passes++;
        checks++; if (op_control !== 3'd1) $display("FAIL single_control got %0d want 1", op_control); else passes++;
        checks++; if (op_a !== 6'd3) $display("FAIL single_a got %0d want 3", op_a); else passes++;
        checks++; if (op_b !== 6'd2) $display("FAIL single_b got %0d want 2", op_b); else passes++;
        checks++; if (hold_cnt - hb != DW) $display("FAIL single_hold got %0d want %0d", hold_cnt - hb, DW); else passes++;
        checks++; if (ops_done !== 2'd1) $display("FAIL single_ops_done got %0d want 1", ops_done); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL single_busy_end got %b want 0", busy); else passes++;
    endtask

    task automatic test_back_to_back();
        int rb, ob, eb, n_ovf;
        logic [14:0] w [3];
        logic        v [3];
        do_reset();
        run_mode = 1'b1;
        rb = ren_cyc.size(); ob = op_seen.size(); eb = ren_empty_err;
        n_ovf = 0;
        for (int i = 0; i < 3; i++) begin
            w[i] = 15'($urandom);
            v[i] = 1'($urandom_range(0, 1));
            n_ovf += int'(v[i]);
            push_word(w[i], v[i]);
        end
        repeat (40) @(negedge clock);
        #1;
        checks++; if (ren_cyc.size() - rb != 3) $display("FAIL b2b_ren_count got %0d want 3", ren_cyc.size() - rb); else passes++;
        for (int i = 1; i < 3; i++) begin
            if (ren_cyc.size() - rb == 3) begin
                checks++;
                if (ren_cyc[rb + i] - ren_cyc[rb + i - 1] != 1 + 1 + 1 + DW)
                    $display("FAIL b2b_spacing%0d got %0d want %0d", i, ren_cyc[rb + i] - ren_cyc[rb + i - 1], 3 + DW);
                else passes++;
            end
        end
        checks++; if (ren_empty_err != eb) $display("FAIL b2b_ren_on_empty got %0d want 0", ren_empty_err - eb); else passes++;
        checks++; if (ops_done !== 2'd3) $display("FAIL b2b_ops_done got %0d want 3", ops_done); else passes++;
        checks++; if (ovf_count !== CW'(n_ovf)) $display("FAIL b2b_ovf_count got %0d want %0d", ovf_count, n_ovf); else passes++;
        for (int i = 0; i < 3; i++) begin
            if (op_seen.size() > ob + i) begin
                checks++;
                if (op_seen[ob + i] !== w[i]) $display("FAIL b2b_word%0d got %h want %h", i, op_seen[ob + i], w[i]);
                else passes++;
            end
        end
    endtask

    task automatic test_step();
        int rb, ob;
        bit found;
        logic [14:0] w0, w1;
        do_reset();
        run_mode = 1'b0;
        rb = ren_cyc.size(); ob = op_seen.size();
        w0 = 15'($urandom); w1 = 15'($urandom);
        push_word(w0, 1'b0);
        push_word(w1, 1'b0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock); #1;
            if (ren) begin found = 1; break; end
        end
        checks++; if (!found) $display("FAIL step_first_ren got none want pulse within 20 cycles"); else passes++;
        @(negedge clock); #1 step = 1'b1;
        @(negedge clock); #1 step = 1'b0;
        repeat (12) @(negedge clock);
        #1;
        checks++; if (holding !== 1'b1) $display("FAIL step_holding got %b want 1", holding); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL step_busy got %b want 1", busy); else passes++;
        checks++; if (ren_cyc.size() - rb != 1) $display("FAIL step_ren_count1 got %0d want 1", ren_cyc.size() - rb); else passes++;
        checks++; if (ops_done !== 2'd1) $display("FAIL step_ops_done1 got %0d want 1", ops_done); else passes++;
        step = 1'b1;
        @(negedge clock); #1 step = 1'b0;
        checks++; if (ren !== 1'b1) $display("FAIL step_second_ren got %b want 1", ren); else passes++;
        checks++; if (holding !== 1'b0) $display("FAIL step_released got %b want 0", holding); else passes++;
        repeat (10) @(negedge clock);
        #1;
        checks++; if (ren_cyc.size() - rb != 2) $display("FAIL step_ren_count2 got %0d want 2", ren_cyc.size() - rb); else passes++;
        checks++; if (ops_done !== 2'd2) $display("FAIL step_ops_done2 got %0d want 2", ops_done); else passes++;
        checks++; if (holding !== 1'b1) $display("FAIL step_holding2 got %b want 1", holding); else passes++;
        if (op_seen.size() - ob == 2) begin
            checks++; if (op_seen[ob] !== w0) $display("FAIL step_word0 got %h want %h", op_seen[ob], w0); else passes++;
            checks++; if (op_seen[ob + 1] !== w1) $display("FAIL step_word1 got %h want %h", op_seen[ob + 1], w1); else passes++;
        end else begin
            checks++; $display("FAIL step_op_count got %0d want 2", op_seen.size() - ob);
        end
        run_mode = 1'b1;
    endtask

    task automatic test_saturation();
        int rb;
        do_reset();
        run_mode = 1'b1;
        rb = ren_cyc.size();
        for (int i = 0; i < 5; i++) push_word(15'($urandom), 1'b1);
        repeat (5 * (3 + DW) + 10) @(negedge clock);
        #1;
        checks++; if (ren_cyc.size() - rb != 5) $display("FAIL sat_ren_count got %0d want 5", ren_cyc.size() - rb); else passes++;
        checks++; if (ops_done !== 2'd3) $display("FAIL sat_ops_done got %0d want 3", ops_done); else passes++;
        checks++; if (ovf_count !== 2'd3) $display("FAIL sat_ovf_count got %0d want 3", ovf_count); else passes++;
    endtask

    task automatic test_random_ovf();
        int k, n_ovf;
        logic v;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            run_mode = 1'b1;
            k = int'($urandom_range(1, 3));
            n_ovf = 0;
            for (int i = 0; i < k; i++) begin
                v = 1'($urandom_range(0, 1));
                n_ovf += int'(v);
                push_word(15'($urandom), v);
            end
            repeat (k * (3 + DW) + 8) @(negedge clock);
            #1;
            checks++; if (ops_done !== CW'(k)) $display("FAIL rnd%0d_ops_done got %0d want %0d", t, ops_done, k); else passes++;
            checks++; if (ovf_count !== CW'(n_ovf)) $display("FAIL rnd%0d_ovf_count got %0d want %0d", t, ovf_count, n_ovf); else passes++;
        end
    endtask

    task automatic test_reset_midop();
        bit found;
        logic [14:0] w0, w1;
        do_reset();
        run_mode = 1'b1;
        w0 = 15'($urandom);
        w1 = 15'($urandom);
        push_word(w0, 1'b1);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock); #1;
            if (op_valid) begin found = 1; break; end
        end
        checks++; if (!found) $display("FAIL midop_reach_exec got none want op_valid within 20 cycles"); else passes++;
        #1 reset = 1'b0;
        #1;
        checks++; if (op_valid !== 1'b0) $display("FAIL midop_op_valid got %b want 0", op_valid); else passes++;
        checks++; if ({op_control, op_a, op_b} !== 15'd0) $display("FAIL midop_fields got %h want 0", {op_control, op_a, op_b}); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midop_busy got %b want 0", busy); else passes++;
        checks++; if (holding !== 1'b0) $display("FAIL midop_holding got %b want 0", holding); else passes++;
        checks++; if (ops_done !== 2'd0) $display("FAIL midop_ops_done got %0d want 0", ops_done); else passes++;
        checks++; if (ovf_count !== 2'd0) $display("FAIL midop_ovf_count got %0d want 0", ovf_count); else passes++;
        repeat (2) @(negedge clock);
        pushed_n = popped_n;
        ovf_wr   = ovf_rd;
        push_word(w1, 1'b0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock); #1;
        checks++; if (ren !== 1'b0) $display("FAIL midop_ren_after_release got %b want 0", ren); else passes++;
        repeat (12) @(negedge clock);
        #1;
        checks++; if (ops_done !== 2'd1) $display("FAIL midop_restart_ops_done got %0d want 1", ops_done); else passes++;
        checks++; if ({op_control, op_a, op_b} !== w1) $display("FAIL midop_restart_word got %h want %h", {op_control, op_a, op_b}, w1); else passes++;
        checks++; if (ovf_count !== 2'd0) $display("FAIL midop_restart_ovf got %0d want 0", ovf_count); else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_step();
        test_saturation();
        test_random_ovf();
        test_reset_midop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
